regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Multi-port ARM register file: NRD combinational read ports and NWR write ports.
//  Index PC_IDX (=NREG-1) reads the externally supplied PC and is never written.
//  Optional same-cycle write-to-read bypass; per-register pending scoreboard for
//  operand-ready tracking; sequential clear engine after reset. Replaces the
//  2R/1W file in the multi-issue datapath.
// PARAMETERS
//  XLEN   32  data width
//  NREG   16  architectural registers incl. PC slot; AW = $clog2(NREG)
//  NRD    3   read ports
//  NWR    2   write ports
//  BYPASS 1   1: a write in progress is visible on same-cycle reads; 0: array only
// PORTS
//  clk         in   1         clock, all state on rising edge
//  reset       in   1         synchronous, active-high
//  pc_in       in   XLEN      value returned for reads of PC_IDX
//  ra          in   NRD*AW    read addresses, port p at [p*AW +: AW]
//  rd          out  NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
//  rd_rdy      out  NRD       operand ready per read port
//  we          in   NWR       write enables
//  wa          in   NWR*AW    write addresses
//  wd          in   NWR*XLEN  write data
//  alloc_en    in   1         mark register alloc_a pending (producer issued)
//  alloc_a     in   AW        register to mark pending
//  busy        out  1         clear engine running; writes/allocs ignored
//  wr_conflict out  1         registered pulse: >=2 enabled ports hit same address
// BEHAVIOUR
//  Reset (edge with reset=1): state<=CLEAR, cnt<=0, busy<=1, pending<=0,
//   wr_conflict<=0. Array contents are not reset directly.
//  CLEAR: each edge with reset=0 writes rf[cnt]<=0, cnt<=cnt+1. On the edge that
//   clears index NREG-2: state<=RUN, busy<=0. busy is high for exactly NREG-1
//   cycles after reset deasserts. Reset during CLEAR restarts at cnt=0.
//  While busy: we and alloc_en ignored, rd_rdy=0, wr_conflict stays 0.
//  Writes (RUN): each port with we[i]=1 and wa[i]!=PC_IDX writes wd[i] at the edge.
//   If several ports hit the same address, the highest index wins; wr_conflict=1
//   on the following cycle only (re-evaluated every cycle).
//   Writes to PC_IDX are dropped silently and never set wr_conflict.
//  Reads (combinational): ra==PC_IDX -> pc_in; else if BYPASS and some write port
//   (RUN, not PC_IDX) targets ra -> wd of highest such port; else rf[ra].
//   ra >= NREG (NREG not a power of 2) -> 0, rd_rdy=1.
//  Scoreboard pending[NREG-2:0]: set by alloc_en at the edge; cleared by any
//   effective write to that index. Alloc and write to the same register in the
//   same cycle -> pending stays 1 (new producer wins). alloc_a==PC_IDX ignored.
//  rd_rdy[p] = !busy && (ra==PC_IDX || !pending[ra] || (BYPASS && effective
//   write to ra this cycle)). With BYPASS=0 readiness follows pending only.
//  No other latency: reads 0 cycles, writes visible in array next cycle.
// TESTING
//  1 reset 1 cycle, NREG=16: busy=1 for 15 cycles then 0; r0..r14 read 0,
//    rd_rdy=3'b111; we asserted during busy leaves r2=0.
//  2 RUN, port0 writes r3=32'hDEADBEEF, ra0=3: BYPASS=1 -> rd0=DEADBEEF same cycle;
//    BYPASS=0 -> rd0 old value, DEADBEEF next cycle.
//  3 port0 r5=32'h11, port1 r5=32'h22 same cycle -> r5=32'h22; wr_conflict=1
//    for exactly one cycle afterwards.
//  4 port0 writes r15=32'h1234, pc_in=32'h8, ra1=15 -> rd1=32'h8, wr_conflict=0.
//  5 alloc r7 -> next cycle rd_rdy for ra=7 is 0; write r7=32'h55 -> rd_rdy=1
//    same cycle (BYPASS=1), pending cleared; alloc+write r7 together -> rd_rdy=0
//    next cycle.
//  6 reset pulsed at 5th CLEAR cycle -> busy stays 1 for 15 more cycles after
//    release; pending cleared; allocs during busy have no effect.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with PC slot, write bypass, pending scoreboard and clear engine
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 16,
  parameter int NRD    = 3,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*XLEN-1:0]  rd,
  output logic [NRD-1:0]       rd_rdy,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wa,
  input  logic [NWR*XLEN-1:0]  wd,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_a,
  output logic                 busy,
  output logic                 wr_conflict
);

  localparam logic [AW-1:0] PC_A     = AW'(NREG - 1);
  localparam logic [AW-1:0] LAST_CLR = AW'(NREG - 2);
  localparam logic [AW:0]   NREG_W   = (AW + 1)'(NREG);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [NREG-2:0] pend_q, pend_d;
  logic            conf_q, conf_d;
  logic [XLEN-1:0] rf_q [NREG-1];

  logic            run;
  logic [NWR-1:0]  w_eff;
  logic [AW-1:0]   w_addr [NWR];
  logic [XLEN-1:0] w_data [NWR];
  logic [AW-1:0]   r_addr [NRD];
  logic [NRD-1:0]  r_hit;
  logic [XLEN-1:0] r_byp  [NRD];

  // Addresses above NREG-1 exist only when NREG is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < NREG_W;
  endfunction

  assign run         = (state_q == S_RUN);
  assign busy        = (state_q == S_CLEAR);
  assign wr_conflict = conf_q;

  always_comb begin
    w_eff = '0;
    for (int i = 0; i < NWR; i++) begin
      w_addr[i] = wa[i*AW +: AW];
      w_data[i] = wd[i*XLEN +: XLEN];
      w_eff[i]  = run && we[i] && (w_addr[i] != PC_A) && in_range(w_addr[i]);
    end
  end

  always_comb begin
    conf_d = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (w_eff[i] && w_eff[j] && (w_addr[i] == w_addr[j])) conf_d = 1'b1;
      end
    end
  end

  // Alloc is applied after the write clears so a new producer keeps the entry pending.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NWR; i++) begin
      if (w_eff[i]) pend_d[w_addr[i]] = 1'b0;
    end
    if (run && alloc_en && (alloc_a != PC_A) && in_range(alloc_a)) pend_d[alloc_a] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CLR) state_d = S_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      conf_q  <= conf_d;
    end
  end

  // Ascending port order makes the highest-index port win on a shared address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        rf_q[cnt_q] <= '0;
      end else begin
        for (int i = 0; i < NWR; i++) begin
          if (w_eff[i]) rf_q[w_addr[i]] <= w_data[i];
        end
      end
    end
  end

  always_comb begin
    rd     = '0;
    rd_rdy = '0;
    r_hit  = '0;
    for (int p = 0; p < NRD; p++) begin
      r_addr[p] = ra[p*AW +: AW];
      r_byp[p]  = '0;
      for (int i = 0; i < NWR; i++) begin
        if (w_eff[i] && (w_addr[i] == r_addr[p])) begin
          r_hit[p] = 1'b1;
          r_byp[p] = w_data[i];
        end
      end
      if (r_addr[p] == PC_A) begin
        rd[p*XLEN +: XLEN] = pc_in;
        rd_rdy[p]          = !busy;
      end else if (!in_range(r_addr[p])) begin
        rd[p*XLEN +: XLEN] = '0;
        rd_rdy[p]          = !busy;
      end else begin
        rd[p*XLEN +: XLEN] = ((BYPASS != 0) && r_hit[p]) ? r_byp[p] : rf_q[r_addr[p]];
        rd_rdy[p]          = !busy && (!pend_q[r_addr[p]] || ((BYPASS != 0) && r_hit[p]));
      end
    end
  end

endmodule
